multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle control unit for the MIPS-subset CPU. A state machine sequences each instruction through IF/ID/EXE/MEM/WB. It produces the PC write enable (PCWre) and next-PC select, plus register-file, ALU and data-memory controls. PCWre is asserted only in the final cycle of each instruction, so the PC register loads the next-PC selector output on that clock edge.

Parameters:
MEM_WAIT, 0, extra wait cycles spent in MEM before leaving it (0..15); covers slow data memory.

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  reset, asynchronous, active-low
opcode  in  6  instruction[31:26] from IR; stable from ID until PCWre edge
zero  in  1  ALU zero flag; sampled in EXE
PCWre  out  1  PC register load enable
IRWre  out  1  instruction register load enable
InsMemRW  out  1  instruction memory read (1 = read)
PCSrc  out  2  00 PC+4, 01 branch target, 10 reserved, 11 jump target
ALUSrcB  out  1  1 = extended immediate, 0 = rt data
ALUOp  out  3  000 add, 001 sub, 011 or, 100 and
ExtSel  out  1  1 = sign-extend immediate, 0 = zero-extend
RegDst  out  2  00 $31, 01 rt, 10 rd
RegWre  out  1  register file write enable
WrRegDSrc  out  1  0 = PC+4, 1 = DB bus
DBDataSrc  out  1  0 = ALU result, 1 = data memory
mRD  out  1  data memory read
mWR  out  1  data memory write
state  out  3  current state encoding
halted  out  1  1 while in HALT

Behaviour:
- Opcodes: ADD 000000, SUB 000001, ADDI 000010, OR 010000, AND 010001, SW 110000, LW 110001, BEQ 110100, BNE 110101, J 111000, HALT 111111. Any other value is unknown.
- States and encodings: IF 000, ID 001, EXE 010, MEM 011, WB 100, HALT 111. State register only; all other outputs decode combinationally from state + opcode (+ zero in EXE).
- Reset (Reset=0, async): state=IF, wait counter=0. While Reset=0, PCWre, IRWre, RegWre and mWR are forced to 0; all other outputs take IF values. Reset asserted mid-instruction aborts it with no register-file or memory write.
- Defaults in every state: all enables 0, PCSrc=00, RegDst=10, WrRegDSrc=1, DBDataSrc=0, ALUOp=000, ALUSrcB=0, ExtSel=1.
- IF: IRWre=1, InsMemRW=1. Next state is ID.
- ID:
  - J: PCWre=1, PCSrc=11, next IF.
  - HALT: next HALT.
  - Unknown opcode: NOP; PCWre=1, PCSrc=00, next IF.
  - Otherwise: next EXE.
- EXE: ALUOp and ALUSrcB are set per opcode. ADDI/LW/SW use ALUSrcB=1, add. BEQ/BNE use sub.
  - BEQ: PCWre=1; PCSrc=01 if zero=1, else 00; next IF.
  - BNE: PCWre=1; PCSrc=01 if zero=0, else 00; next IF.
  - LW/SW: next MEM.
  - Others: next WB.
- ALU controls (ALUOp, ALUSrcB) are held through MEM and WB.
- MEM: mRD=1 for LW; mWR=1 for SW. Wait counter increments each MEM cycle and leaves when counter==MEM_WAIT, so MEM lasts MEM_WAIT+1 cycles. Counter clears on exit.
  - SW: PCWre=1 only in the final MEM cycle; next IF.
  - LW: next WB.
  - mWR is asserted for every MEM cycle of SW.
- WB: RegWre=1, PCWre=1, PCSrc=00. RegDst=01 for ADDI/LW, 10 for R-type. DBDataSrc=1 for LW. Next IF.
- HALT: halted=1, all enables 0, stays until reset.
- Cycles per instruction (MEM_WAIT=0): J/NOP 2, BEQ/BNE 3, R-type/ADDI 4, SW 4, LW 5.
- PCWre is 1 in exactly one cycle per instruction, never in IF.

Optional Feature:
- Macro: MULTI_CYCLE_CTRL_JAL_EN.
- With macro: opcode 111010 = JAL. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1, PCSrc=11, next IF.
- Without macro: 111010 is unknown and executes as a NOP. WrRegDSrc is still present as a port and stays 1.

Test Plan:
- Reset low mid-WB of ADD, held 2 cycles → state=000, PCWre=0, RegWre=0 during reset. After release, IRWre=1 for one cycle, then state=001.
- ADD (000000) from reset → states 000,001,010,100,000. PCWre=1 and RegWre=1 only in WB. RegDst=10.
- BEQ: zero=1 → PCWre=1, PCSrc=01 in EXE. zero=0 → PCSrc=00. BNE gives the inverted result. Each takes 3 cycles.
- MEM_WAIT=2, LW → MEM lasts 3 cycles with mRD=1, then WB with DBDataSrc=1, RegDst=01, RegWre=1. Total 7 cycles.
- SW then J → SW: mWR=1 for all MEM cycles, PCWre only in last one. J: PCWre=1, PCSrc=11 in ID, 2 cycles.
- HALT (111111) → state=111, halted=1, no enables for 20 cycles. Opcode 111010 gives a JAL-write cycle (macro on) or a 2-cycle NOP (macro off).

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle control unit for the MIPS-subset CPU.
// Sequences each instruction through IF/ID/EXE/MEM/WB and decodes the
// datapath controls combinationally from the current state and opcode.
// PCWre fires in exactly one cycle per instruction (its last cycle).
//
// Optional build macro: MULTI_CYCLE_CTRL_JAL_EN
//   defined   -> opcode 111010 executes as JAL ($31 <= PC+4, PC <= jump target)
//   undefined -> opcode 111010 is unknown and runs as a 2-cycle NOP
//
// state | meaning
// ------+-------------------------------------------------------------
// IF    | fetch: load IR from instruction memory
// ID    | decode; J / JAL / NOP finish here, HALT parks
// EXE   | ALU operation; BEQ / BNE finish here
// MEM   | data memory access, held MEM_WAIT+1 cycles; SW finishes here
// WB    | register file write-back, PC update
// HALT  | stopped until reset
module multi_cycle_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic [1:0] PCSrc,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic [1:0] RegDst,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [2:0] state,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXE  = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_JAL  = 6'b111010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;

    logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_halt;
    logic is_jal, is_known;
    logic [2:0] alu_op_dec;
    logic       alu_srcb_dec;

    // Enables before the reset gate; reset must never let a write through.
    logic pc_wre_raw, ir_wre_raw, reg_wre_raw, m_wr_raw;

    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_OR)  || (opcode == OP_AND);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_bne   = (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);
    assign is_halt  = (opcode == OP_HALT);

`ifdef MULTI_CYCLE_CTRL_JAL_EN
    assign is_jal   = (opcode == OP_JAL);
`else
    assign is_jal   = 1'b0;
`endif

    assign is_known = is_rtype || is_addi || is_lw || is_sw || is_beq ||
                      is_bne || is_j || is_halt || is_jal;

    // ALU operation and B-operand select per opcode; held from EXE to WB.
    always_comb begin
        alu_op_dec   = ALU_ADD;
        alu_srcb_dec = 1'b0;
        case (opcode)
            OP_SUB:              alu_op_dec = ALU_SUB;
            OP_OR:               alu_op_dec = ALU_OR;
            OP_AND:              alu_op_dec = ALU_AND;
            OP_BEQ, OP_BNE:      alu_op_dec = ALU_SUB;
            OP_ADDI, OP_LW, OP_SW: alu_srcb_dec = 1'b1;
            default: begin
                alu_op_dec   = ALU_ADD;
                alu_srcb_dec = 1'b0;
            end
        endcase
    end

    // State register and MEM wait counter.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IF;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state and control decode from state + opcode (+ zero in EXE).
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        pc_wre_raw  = 1'b0;
        ir_wre_raw  = 1'b0;
        reg_wre_raw = 1'b0;
        m_wr_raw    = 1'b0;
        InsMemRW    = 1'b0;
        PCSrc       = 2'b00;
        ALUSrcB     = 1'b0;
        ALUOp       = ALU_ADD;
        ExtSel      = 1'b1;
        RegDst      = 2'b10;
        WrRegDSrc   = 1'b1;
        DBDataSrc   = 1'b0;
        mRD         = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IF: begin
                ir_wre_raw = 1'b1;
                InsMemRW   = 1'b1;
                state_d    = ST_ID;
            end

            ST_ID: begin
                if (is_j) begin
                    pc_wre_raw = 1'b1;
                    PCSrc      = 2'b11;
                    state_d    = ST_IF;
                end else if (is_jal) begin
                    reg_wre_raw = 1'b1;
                    RegDst      = 2'b00;
                    WrRegDSrc   = 1'b0;
                    pc_wre_raw  = 1'b1;
                    PCSrc       = 2'b11;
                    state_d     = ST_IF;
                end else if (is_halt) begin
                    state_d = ST_HALT;
                end else if (!is_known) begin
                    pc_wre_raw = 1'b1;
                    state_d    = ST_IF;
                end else begin
                    state_d = ST_EXE;
                end
            end

            ST_EXE: begin
                ALUOp   = alu_op_dec;
                ALUSrcB = alu_srcb_dec;
                if (is_beq || is_bne) begin
                    pc_wre_raw = 1'b1;
                    PCSrc      = ((is_beq && zero) || (is_bne && !zero)) ? 2'b01 : 2'b00;
                    state_d    = ST_IF;
                end else if (is_lw || is_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_MEM: begin
                ALUOp    = alu_op_dec;
                ALUSrcB  = alu_srcb_dec;
                mRD      = is_lw;
                m_wr_raw = is_sw;
                if (wcnt_q == WAIT_LAST) begin
                    wcnt_d = 4'd0;
                    if (is_sw) begin
                        pc_wre_raw = 1'b1;
                        state_d    = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end

            ST_WB: begin
                ALUOp       = alu_op_dec;
                ALUSrcB     = alu_srcb_dec;
                reg_wre_raw = 1'b1;
                pc_wre_raw  = 1'b1;
                RegDst      = (is_addi || is_lw) ? 2'b01 : 2'b10;
                DBDataSrc   = is_lw;
                state_d     = ST_IF;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_IF;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    assign PCWre  = pc_wre_raw  & Reset;
    assign IRWre  = ir_wre_raw  & Reset;
    assign RegWre = reg_wre_raw & Reset;
    assign mWR    = m_wr_raw    & Reset;
    assign state  = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: self-checking bench for multi_cycle_ctrl.
// Expected per-cycle control vectors come from an instruction-level
// model that lists the cycles each opcode class must take.
module tb_multi_cycle_ctrl;

    localparam int unsigned MW = 2;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_X3A  = 6'b111010;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre;
        logic       irwre;
        logic       insmem;
        logic [1:0] pcsrc;
        logic       alusrcb;
        logic [2:0] aluop;
        logic       extsel;
        logic [1:0] regdst;
        logic       regwre;
        logic       wrregdsrc;
        logic       dbdatasrc;
        logic       mrd;
        logic       mwr;
        logic       halted;
    } vec_t;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       PCWre, IRWre, InsMemRW, ALUSrcB, ExtSel, RegWre;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR, halted;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t q_exp[$];

    always #5 CLK = ~CLK;

    multi_cycle_ctrl #(.MEM_WAIT(MW)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .PCSrc(PCSrc),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst),
        .RegWre(RegWre), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .state(state), .halted(halted)
    );

    function automatic vec_t obs();
        vec_t v;
        v.st = state; v.pcwre = PCWre; v.irwre = IRWre; v.insmem = InsMemRW;
        v.pcsrc = PCSrc; v.alusrcb = ALUSrcB; v.aluop = ALUOp; v.extsel = ExtSel;
        v.regdst = RegDst; v.regwre = RegWre; v.wrregdsrc = WrRegDSrc;
        v.dbdatasrc = DBDataSrc; v.mrd = mRD; v.mwr = mWR; v.halted = halted;
        return v;
    endfunction

    function automatic vec_t base(input logic [2:0] st);
        vec_t v;
        v = '0;
        v.st = st; v.regdst = 2'b10; v.wrregdsrc = 1'b1; v.extsel = 1'b1;
        v.halted = (st == 3'b111);
        return v;
    endfunction

    function automatic vec_t reset_vec();
        vec_t v;
        v = base(3'b000);
        v.insmem = 1'b1;
        return v;
    endfunction

    // Instruction-level model: builds the list of cycles for one instruction.
    // Classes: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 J, 7 HALT, 8 JAL, 9 NOP.
    task automatic model_instr(input logic [5:0] op, input logic z);
        int         cls;
        logic [2:0] alu;
        logic       srcb;
        logic       taken;
        vec_t       v;
        q_exp.delete();
        alu = 3'b000; srcb = 1'b0;
        case (op)
            OP_ADD:  cls = 0;
            OP_SUB:  begin cls = 0; alu = 3'b001; end
            OP_OR:   begin cls = 0; alu = 3'b011; end
            OP_AND:  begin cls = 0; alu = 3'b100; end
            OP_ADDI: begin cls = 1; srcb = 1'b1; end
            OP_LW:   begin cls = 2; srcb = 1'b1; end
            OP_SW:   begin cls = 3; srcb = 1'b1; end
            OP_BEQ:  begin cls = 4; alu = 3'b001; end
            OP_BNE:  begin cls = 5; alu = 3'b001; end
            OP_J:    cls = 6;
            OP_HALT: cls = 7;
`ifdef MULTI_CYCLE_CTRL_JAL_EN
            OP_X3A:  cls = 8;
`endif
            default: cls = 9;
        endcase

        v = base(3'b000); v.irwre = 1'b1; v.insmem = 1'b1;
        q_exp.push_back(v);

        v = base(3'b001);
        if (cls == 6) begin
            v.pcwre = 1'b1; v.pcsrc = 2'b11; q_exp.push_back(v); return;
        end
        if (cls == 8) begin
            v.pcwre = 1'b1; v.pcsrc = 2'b11; v.regwre = 1'b1;
            v.regdst = 2'b00; v.wrregdsrc = 1'b0; q_exp.push_back(v); return;
        end
        if (cls == 9) begin
            v.pcwre = 1'b1; q_exp.push_back(v); return;
        end
        q_exp.push_back(v);
        if (cls == 7) return;

        v = base(3'b010); v.aluop = alu; v.alusrcb = srcb;
        if (cls == 4 || cls == 5) begin
            taken = (cls == 4) ? z : !z;
            v.pcwre = 1'b1; v.pcsrc = taken ? 2'b01 : 2'b00;
            q_exp.push_back(v); return;
        end
        q_exp.push_back(v);

        if (cls == 2 || cls == 3) begin
            for (int k = 0; k <= int'(MW); k++) begin
                v = base(3'b011); v.aluop = alu; v.alusrcb = srcb;
                v.mrd = (cls == 2); v.mwr = (cls == 3);
                v.pcwre = (cls == 3) && (k == int'(MW));
                q_exp.push_back(v);
            end
            if (cls == 3) return;
        end

        v = base(3'b100); v.aluop = alu; v.alusrcb = srcb;
        v.regwre = 1'b1; v.pcwre = 1'b1;
        v.regdst = (cls == 1 || cls == 2) ? 2'b01 : 2'b10;
        v.dbdatasrc = (cls == 2);
        q_exp.push_back(v);
    endtask

    task automatic test_reset();
        vec_t ov;
        @(negedge CLK);
        ov = obs(); n_cmp++;
        if (ov !== reset_vec()) begin
            n_err++; $display("FAIL reset_hold: got %h need %h", ov, reset_vec());
        end
        @(posedge CLK); #1;
        Reset = 1'b1;
    endtask

    task automatic test_add();
        vec_t ov;
        opcode = OP_ADD; zero = 1'b0;
        model_instr(OP_ADD, 1'b0);
        foreach (q_exp[k]) begin
            @(negedge CLK); ov = obs(); n_cmp++;
            if (ov !== q_exp[k]) begin
                n_err++; $display("FAIL add cyc%0d: got %h need %h", k, ov, q_exp[k]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch();
        vec_t ov;
        logic [5:0] ops[4];
        logic       zs[4];
        ops = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i]; zero = zs[i];
            model_instr(ops[i], zs[i]);
            foreach (q_exp[k]) begin
                @(negedge CLK); ov = obs(); n_cmp++;
                if (ov !== q_exp[k]) begin
                    n_err++;
                    $display("FAIL branch op=%b z=%b cyc%0d: got %h need %h",
                             ops[i], zs[i], k, ov, q_exp[k]);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_lw();
        vec_t ov;
        opcode = OP_LW; zero = 1'b1;
        model_instr(OP_LW, 1'b1);
        foreach (q_exp[k]) begin
            @(negedge CLK); ov = obs(); n_cmp++;
            if (ov !== q_exp[k]) begin
                n_err++; $display("FAIL lw cyc%0d: got %h need %h", k, ov, q_exp[k]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_sw_j();
        vec_t ov;
        logic [5:0] ops[2];
        ops = '{OP_SW, OP_J};
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i]; zero = 1'b0;
            model_instr(ops[i], 1'b0);
            foreach (q_exp[k]) begin
                @(negedge CLK); ov = obs(); n_cmp++;
                if (ov !== q_exp[k]) begin
                    n_err++;
                    $display("FAIL sw_j op=%b cyc%0d: got %h need %h", ops[i], k, ov, q_exp[k]);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_op_111010();
        vec_t ov;
        opcode = OP_X3A; zero = 1'b0;
        model_instr(OP_X3A, 1'b0);
        foreach (q_exp[k]) begin
            @(negedge CLK); ov = obs(); n_cmp++;
            if (ov !== q_exp[k]) begin
                n_err++; $display("FAIL op111010 cyc%0d: got %h need %h", k, ov, q_exp[k]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid();
        vec_t ov;
        opcode = OP_ADD; zero = 1'b0;
        model_instr(OP_ADD, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); ov = obs(); n_cmp++;
            if (ov !== q_exp[k]) begin
                n_err++; $display("FAIL rstmid_pre cyc%0d: got %h need %h", k, ov, q_exp[k]);
            end
            if (k < 3) begin
                @(posedge CLK); #1;
            end
        end
        #1 Reset = 1'b0;
        #1;
        ov = obs(); n_cmp++;
        if (ov !== reset_vec()) begin
            n_err++; $display("FAIL rstmid_assert: got %h need %h", ov, reset_vec());
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK);
            @(negedge CLK); ov = obs(); n_cmp++;
            if (ov !== reset_vec()) begin
                n_err++; $display("FAIL rstmid_hold%0d: got %h need %h", c, ov, reset_vec());
            end
        end
        @(posedge CLK); #1;
        Reset = 1'b1;
        foreach (q_exp[k]) begin
            @(negedge CLK); ov = obs(); n_cmp++;
            if (ov !== q_exp[k]) begin
                n_err++; $display("FAIL rstmid_post cyc%0d: got %h need %h", k, ov, q_exp[k]);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_random();
        vec_t ov;
        logic [5:0] ops[10];
        logic [5:0] op;
        logic       z;
        int         sel;
        ops = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J};
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 11);
            if (sel < 10) op = ops[sel];
            else op = 6'($urandom_range(0, 62));
            z = 1'($urandom_range(0, 1));
            opcode = op; zero = z;
            model_instr(op, z);
            foreach (q_exp[k]) begin
                @(negedge CLK); ov = obs(); n_cmp++;
                if (ov !== q_exp[k]) begin
                    n_err++;
                    $display("FAIL random#%0d op=%b z=%b cyc%0d: got %h need %h",
                             i, op, z, k, ov, q_exp[k]);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic test_halt();
        vec_t ov;
        opcode = OP_HALT; zero = 1'b0;
        model_instr(OP_HALT, 1'b0);
        foreach (q_exp[k]) begin
            @(negedge CLK); ov = obs(); n_cmp++;
            if (ov !== q_exp[k]) begin
                n_err++; $display("FAIL halt_entry cyc%0d: got %h need %h", k, ov, q_exp[k]);
            end
            @(posedge CLK); #1;
        end
        for (int c = 0; c < 20; c++) begin
            opcode = (c % 2 == 0) ? OP_J : OP_ADD;
            zero = 1'($urandom_range(0, 1));
            @(negedge CLK); ov = obs(); n_cmp++;
            if (ov !== base(3'b111)) begin
                n_err++; $display("FAIL halt_stay cyc%0d: got %h need %h", c, ov, base(3'b111));
            end
            @(posedge CLK); #1;
        end
        Reset = 1'b0;
        #1;
        ov = obs(); n_cmp++;
        if (ov !== reset_vec()) begin
            n_err++; $display("FAIL halt_reset: got %h need %h", ov, reset_vec());
        end
        @(posedge CLK); #1;
        Reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_lw();
        test_sw_j();
        test_op_111010();
        test_reset_mid();
        test_random();
        test_halt();
        test_add();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
